// File: rtl/stream_fifo_share_ctrl_pkg.sv
// Shared types and helpers for stream-sharing controllers: FSM state, width helpers, and
// round-robin pointer wrap.
package stream_ctrl_pkg;

  typedef enum logic [0:0] {IDLE, XFER} ctrl_state_e;

  localparam int unsigned DEF_N_SRC     = 4;
  localparam int unsigned DEF_BURST_LEN = 64;

  // Width of an index into n items, never below one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned DEF_ID_W  = idx_width(DEF_N_SRC);
  localparam int unsigned DEF_CNT_W = idx_width(DEF_BURST_LEN);

  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/stream_fifo_share_ctrl_if.sv
// Bundle of producer streams, FIFO in0 stream and status between the sharing controller and
// its environment.
interface stream_fifo_share_ctrl_if #(
  parameter int unsigned N_SRC = 4,
  parameter int unsigned WIDTH = 96,
  parameter int unsigned CNT_W = 14,
  parameter int unsigned ID_W  = 2
);
  logic [N_SRC*WIDTH-1:0] s_tdata;
  logic [N_SRC-1:0]       s_tvalid;
  logic [N_SRC-1:0]       s_tready;
  logic [CNT_W-1:0]       fifo_count;
  logic [WIDTH-1:0]       m_tdata;
  logic                   m_tvalid;
  logic                   m_tready;
  logic [ID_W-1:0]        m_tid;
  logic                   busy;
  logic [N_SRC-1:0]       grant_onehot;

  // Controller view.
  modport master (
    input  s_tdata, s_tvalid, fifo_count, m_tready,
    output s_tready, m_tdata, m_tvalid, m_tid, busy, grant_onehot
  );

  // Environment view: producers, FIFO and monitors.
  modport slave (
    output s_tdata, s_tvalid, fifo_count, m_tready,
    input  s_tready, m_tdata, m_tvalid, m_tid, busy, grant_onehot
  );
endinterface

// File: rtl/stream_fifo_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping modulo N.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] idx,
  output logic            valid
);

  always_comb begin
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < int'(N); i++) begin
      j = (int'(ptr) + i) % int'(N);
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/stream_fifo_share_ctrl.sv
// Round-robin burst scheduler letting N_SRC stream producers share one FIFO; each grant
// carries exactly BURST_LEN beats and is admitted only if the FIFO has room for all of them.
module stream_fifo_share_ctrl
  import stream_ctrl_pkg::*;
#(
  parameter int unsigned N_SRC      = 4,
  parameter int unsigned WIDTH      = 96,
  parameter int unsigned BURST_LEN  = 64,
  parameter int unsigned FIFO_DEPTH = 16384,
  parameter int unsigned CNT_W      = 14
) (
  input logic                    ap_clk,
  input logic                    ap_rst_n,
  stream_fifo_share_ctrl_if.master bus
);

  localparam int unsigned ID_W  = idx_width(N_SRC);
  localparam int unsigned BCW   = idx_width(BURST_LEN);
  localparam int unsigned ROOMW = CNT_W + 1;

  localparam logic [BCW-1:0]   LAST_BEAT = BCW'(BURST_LEN - 1);
  localparam logic [ROOMW-1:0] DEPTH_W   = ROOMW'(FIFO_DEPTH);
  localparam logic [ROOMW-1:0] BURST_W   = ROOMW'(BURST_LEN);

  ctrl_state_e      state_q, state_d;
  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic [N_SRC-1:0] gnt_q, gnt_d;
  logic [BCW-1:0]   cnt_q, cnt_d;

  logic [N_SRC-1:0] arb_gnt;
  logic [ID_W-1:0]  arb_idx;
  logic             arb_valid;
  logic [ROOMW-1:0] count_w, room;
  logic             space_ok;
  logic             xfer;
  logic             beat;

  rr_arbiter #(
    .N    (N_SRC),
    .ID_W (ID_W)
  ) u_arb (
    .req   (bus.s_tvalid),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  // A count above depth would wrap the subtraction; treat it as no room.
  assign count_w  = {1'b0, bus.fifo_count};
  assign room     = DEPTH_W - count_w;
  assign space_ok = (count_w <= DEPTH_W) && (room >= BURST_W);

  assign xfer = (state_q == XFER);
  assign beat = bus.m_tvalid && bus.m_tready;

  always_comb begin
    bus.m_tdata  = '0;
    bus.m_tvalid = 1'b0;
    bus.s_tready = '0;
    for (int i = 0; i < int'(N_SRC); i++) begin
      if (id_q == ID_W'(i)) begin
        bus.m_tdata     = bus.s_tdata[i*WIDTH +: WIDTH];
        bus.m_tvalid    = xfer && bus.s_tvalid[i];
        bus.s_tready[i] = xfer && bus.m_tready;
      end
    end
  end

  assign bus.m_tid        = id_q;
  assign bus.busy         = xfer;
  assign bus.grant_onehot = gnt_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    id_d    = id_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (arb_valid && space_ok) begin
          state_d = XFER;
          id_d    = arb_idx;
          gnt_d   = arb_gnt;
          cnt_d   = '0;
        end
      end
      XFER: begin
        if (beat) begin
          if (cnt_q == LAST_BEAT) begin
            state_d = IDLE;
            ptr_d   = ID_W'(rr_next(32'(id_q), N_SRC));
            gnt_d   = '0;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      id_q    <= '0;
      gnt_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      id_q    <= id_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_stream_fifo_share_ctrl.sv
// Directed bench for stream_fifo_share_ctrl with 4 sources, 4-beat bursts and a 16K FIFO.
module tb_stream_fifo_share_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned W  = 16;
  localparam int unsigned BL = 4;
  localparam int unsigned DP = 16384;
  localparam int unsigned CW = 14;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   beats = 0;
  int   seq [N];
  logic [W-1:0] dq [$];

  always #5 clk = ~clk;

  stream_fifo_share_ctrl_if #(.N_SRC(N), .WIDTH(W), .CNT_W(CW), .ID_W(2)) bus ();

  stream_fifo_share_ctrl #(
    .N_SRC      (N),
    .WIDTH      (W),
    .BURST_LEN  (BL),
    .FIFO_DEPTH (DP),
    .CNT_W      (CW)
  ) dut (
    .ap_clk   (clk),
    .ap_rst_n (rst_n),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each producer presents {id, sequence number}, advancing on its own handshakes.
  task automatic drive_data();
    for (int i = 0; i < int'(N); i++) bus.s_tdata[i*W +: W] = W'(i * 256 + seq[i]);
  endtask

  task automatic tick();
    logic [N-1:0] fire;
    #1;
    fire = bus.s_tvalid & bus.s_tready;
    if (rst_n && bus.m_tvalid && bus.m_tready) begin
      beats++;
      dq.push_back(bus.m_tdata);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < int'(N); i++) if (fire[i]) seq[i]++;
    drive_data();
    #1;
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) seq[i] = 0;
    bus.s_tvalid   = 4'b1111;
    bus.m_tready   = 1'b1;
    bus.fifo_count = '0;
    drive_data();

    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_s_tready", 32'(bus.s_tready), 32'h0);
      chk("rst_m_tvalid", 32'(bus.m_tvalid), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_grant", 32'(bus.grant_onehot), 32'h0);
    end
    chk("rst_m_tid", 32'(bus.m_tid), 32'h0);

    // Round robin: 0,1,2,3,0, four beats each, one idle cycle between bursts.
    for (int i = 0; i < int'(N); i++) seq[i] = 0;
    drive_data();
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      int b, id, rnd, ph;
      tick();
      b = c / 5; id = b % 4; rnd = b / 4; ph = c % 5;
      if (ph < 4) begin
        chk("rr_busy", 32'(bus.busy), 32'h1);
        chk("rr_tid", 32'(bus.m_tid), 32'(id));
        chk("rr_grant", 32'(bus.grant_onehot), 32'(1 << id));
        chk("rr_s_tready", 32'(bus.s_tready), 32'(1 << id));
        chk("rr_data", 32'(bus.m_tdata), 32'(id * 256 + rnd * 4 + ph));
      end else begin
        chk("rr_gap_busy", 32'(bus.busy), 32'h0);
        chk("rr_gap_tvalid", 32'(bus.m_tvalid), 32'h0);
      end
    end

    // Admission: room of BURST_LEN-1 is refused, exactly BURST_LEN admitted.
    bus.s_tvalid   = 4'b0100;
    bus.fifo_count = CW'(DP - BL + 1);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("adm_blocked_busy", 32'(bus.busy), 32'h0);
    end
    bus.fifo_count = CW'(DP - BL);
    tick();
    chk("adm_busy", 32'(bus.busy), 32'h1);
    chk("adm_tid", 32'(bus.m_tid), 32'h2);
    chk("adm_grant", 32'(bus.grant_onehot), 32'h4);
    chk("adm_data", 32'(bus.m_tdata), 32'h0204);
    beats = 0;
    for (int k = 0; k < int'(BL); k++) tick();
    chk("adm_end_busy", 32'(bus.busy), 32'h0);
    chk("adm_beats", 32'(beats), 32'(BL));
    chk("idle_tid_hold", 32'(bus.m_tid), 32'h2);

    // Wrap priority: pointer is 3, only sources 0 and 1 request.
    bus.fifo_count = '0;
    bus.s_tvalid   = 4'b0011;
    tick();
    chk("wrap_tid0", 32'(bus.m_tid), 32'h0);
    chk("wrap_grant0", 32'(bus.grant_onehot), 32'h1);
    for (int k = 0; k < int'(BL); k++) tick();
    chk("wrap_gap_busy", 32'(bus.busy), 32'h0);
    tick();
    chk("wrap_tid1", 32'(bus.m_tid), 32'h1);
    chk("wrap_grant1", 32'(bus.grant_onehot), 32'h2);

    // Stalls on the source-1 burst: FIFO backpressure, then source bubble.
    beats = 0;
    dq.delete();
    tick();
    tick();
    chk("stall_pre_beats", 32'(beats), 32'h2);
    bus.m_tready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("stall_rdy_grant", 32'(bus.grant_onehot), 32'h2);
      chk("stall_rdy_s_tready", 32'(bus.s_tready), 32'h0);
    end
    chk("stall_rdy_beats", 32'(beats), 32'h2);
    bus.m_tready = 1'b1;
    bus.s_tvalid = 4'b0001;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_vld_tvalid", 32'(bus.m_tvalid), 32'h0);
      chk("stall_vld_busy", 32'(bus.busy), 32'h1);
      chk("stall_vld_grant", 32'(bus.grant_onehot), 32'h2);
    end
    chk("stall_vld_beats", 32'(beats), 32'h2);
    bus.s_tvalid = 4'b0011;
    tick();
    chk("stall_mid_busy", 32'(bus.busy), 32'h1);
    tick();
    chk("stall_end_busy", 32'(bus.busy), 32'h0);
    chk("stall_beats", 32'(beats), 32'(BL));
    chk("stall_dq_len", 32'(dq.size()), 32'(BL));
    for (int k = 0; k < dq.size(); k++) chk("stall_order", 32'(dq[k]), 32'(16'h0104 + k));

    // Reset two beats into a source-1 burst.
    bus.s_tvalid = 4'b0010;
    tick();
    chk("mrst_tid", 32'(bus.m_tid), 32'h1);
    beats = 0;
    tick();
    tick();
    chk("mrst_beats", 32'(beats), 32'h2);
    rst_n = 1'b0;
    tick();
    chk("mrst_busy", 32'(bus.busy), 32'h0);
    chk("mrst_grant", 32'(bus.grant_onehot), 32'h0);
    chk("mrst_tvalid", 32'(bus.m_tvalid), 32'h0);
    chk("mrst_s_tready", 32'(bus.s_tready), 32'h0);
    chk("mrst_tid_clear", 32'(bus.m_tid), 32'h0);
    rst_n = 1'b1;
    bus.s_tvalid = 4'b1111;
    tick();
    chk("mrst_regrant_tid", 32'(bus.m_tid), 32'h0);
    chk("mrst_regrant_grant", 32'(bus.grant_onehot), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
